// File: rtl/brush_stamp_ctrl_if.sv
// Framebuffer pixel-write port: valid/ready handshake carrying coordinates,
// linear address and colour.
interface brush_stamp_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              wr_valid_out;
    logic              wr_ready_in;
    logic [9:0]        wr_x_out;
    logic [8:0]        wr_y_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [3:0]        wr_data_out;

    modport master (
        output wr_valid_out, wr_x_out, wr_y_out, wr_addr_out, wr_data_out,
        input  wr_ready_in
    );

    modport slave (
        input  wr_valid_out, wr_x_out, wr_y_out, wr_addr_out, wr_data_out,
        output wr_ready_in
    );
endinterface

// File: rtl/brush_stamp_ctrl.sv
// Stamps a clipped square brush around the cursor into the framebuffer,
// one pixel write per handshake, once per qualifying new-frame strobe.
module brush_stamp_ctrl #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 360,
    parameter int ADDR_W    = 18
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [9:0]        cursor_x_in,
    input  logic [8:0]        cursor_y_in,
    input  logic [3:0]        color_in,
    input  logic [2:0]        stroke_width_in,
    input  logic              draw_en_in,
    input  logic              nf_in,
    brush_stamp_ctrl_if.master wr,
    output logic              busy_out,
    output logic              done_out,
    output logic              frame_miss_out
);

    typedef enum logic [1:0] {IDLE, LATCH, STAMP, DONE} state_t;

    localparam logic signed [11:0] X_MAX   = 12'(FB_WIDTH - 1);
    localparam logic signed [11:0] Y_MAX   = 12'(FB_HEIGHT - 1);
    localparam logic [ADDR_W-1:0]  ROW_INC = ADDR_W'(FB_WIDTH);

    state_t            state_reg;
    logic [9:0]        cx_reg;
    logic [8:0]        cy_reg;
    logic [3:0]        col_reg;
    logic [2:0]        rad_reg;
    logic [9:0]        x_lo_reg;
    logic [9:0]        x_hi_reg;
    logic [8:0]        y_hi_reg;
    logic [9:0]        wr_x_reg;
    logic [8:0]        wr_y_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] row_base_reg;
    logic              valid_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              miss_reg;

    logic signed [11:0] xs, ys, rs;
    logic signed [11:0] x_lo_c, x_hi_c, y_lo_c, y_hi_c;
    logic               empty_c;
    logic [ADDR_W-1:0]  row_base_c;

    // Clipped bounds from the captured cursor; the one multiply happens here,
    // outside the per-pixel loop.
    always_comb begin
        xs         = $signed({2'b00, cx_reg});
        ys         = $signed({3'b000, cy_reg});
        rs         = $signed({9'd0, rad_reg});
        x_lo_c     = (xs < rs) ? 12'sd0 : (xs - rs);
        x_hi_c     = ((xs + rs) > X_MAX) ? X_MAX : (xs + rs);
        y_lo_c     = (ys < rs) ? 12'sd0 : (ys - rs);
        y_hi_c     = ((ys + rs) > Y_MAX) ? Y_MAX : (ys + rs);
        empty_c    = (x_lo_c > x_hi_c) || (y_lo_c > y_hi_c);
        row_base_c = ADDR_W'(y_lo_c[8:0]) * ROW_INC;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= IDLE;
            cx_reg       <= '0;
            cy_reg       <= '0;
            col_reg      <= '0;
            rad_reg      <= '0;
            x_lo_reg     <= '0;
            x_hi_reg     <= '0;
            y_hi_reg     <= '0;
            wr_x_reg     <= '0;
            wr_y_reg     <= '0;
            addr_reg     <= '0;
            row_base_reg <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            miss_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (nf_in && (state_reg != IDLE))
                miss_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (nf_in && draw_en_in) begin
                        cx_reg    <= cursor_x_in;
                        cy_reg    <= cursor_y_in;
                        col_reg   <= color_in;
                        rad_reg   <= stroke_width_in;
                        busy_reg  <= 1'b1;
                        state_reg <= LATCH;
                    end
                end
                LATCH: begin
                    x_lo_reg <= x_lo_c[9:0];
                    x_hi_reg <= x_hi_c[9:0];
                    y_hi_reg <= y_hi_c[8:0];
                    if (empty_c) begin
                        state_reg <= DONE;
                    end else begin
                        wr_x_reg     <= x_lo_c[9:0];
                        wr_y_reg     <= y_lo_c[8:0];
                        row_base_reg <= row_base_c;
                        addr_reg     <= row_base_c + ADDR_W'(x_lo_c[9:0]);
                        valid_reg    <= 1'b1;
                        state_reg    <= STAMP;
                    end
                end
                STAMP: begin
                    if (valid_reg && wr.wr_ready_in) begin
                        if (wr_x_reg < x_hi_reg) begin
                            wr_x_reg <= wr_x_reg + 10'd1;
                            addr_reg <= addr_reg + 1'b1;
                        end else if (wr_y_reg < y_hi_reg) begin
                            wr_x_reg     <= x_lo_reg;
                            wr_y_reg     <= wr_y_reg + 9'd1;
                            row_base_reg <= row_base_reg + ROW_INC;
                            addr_reg     <= row_base_reg + ROW_INC + ADDR_W'(x_lo_reg);
                        end else begin
                            valid_reg <= 1'b0;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wr.wr_valid_out = valid_reg;
    assign wr.wr_x_out     = wr_x_reg;
    assign wr.wr_y_out     = wr_y_reg;
    assign wr.wr_addr_out  = addr_reg;
    assign wr.wr_data_out  = col_reg;
    assign busy_out        = busy_reg;
    assign done_out        = done_reg;
    assign frame_miss_out  = miss_reg;

endmodule

// File: tb/tb_brush_stamp_ctrl.sv
// Directed bench for brush_stamp_ctrl: logs every handshake and checks
// addresses, timing, stalls, clipping, frame misses and async reset.
module tb_brush_stamp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] cursor_x;
    logic [8:0] cursor_y;
    logic [3:0] color;
    logic [2:0] stroke_width;
    logic       draw_en;
    logic       nf;
    logic       busy, done, frame_miss;

    brush_stamp_ctrl_if #(.ADDR_W(18)) wr ();

    brush_stamp_ctrl #(.FB_WIDTH(640), .FB_HEIGHT(360), .ADDR_W(18)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .cursor_x_in    (cursor_x),
        .cursor_y_in    (cursor_y),
        .color_in       (color),
        .stroke_width_in(stroke_width),
        .draw_en_in     (draw_en),
        .nf_in          (nf),
        .wr             (wr.master),
        .busy_out       (busy),
        .done_out       (done),
        .frame_miss_out (frame_miss)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned wa_q[$];
    int          we_q[$];
    int unsigned wd_q[$];
    int          done_cnt = 0;
    bit          busy_hist[0:8191];
    bit          done_hist[0:8191];

    // After edge k (cyc==k) a valid&&ready seen here completes at edge k+1.
    always @(negedge clk) begin
        busy_hist[cyc & 8191] = busy;
        done_hist[cyc & 8191] = done;
        if (done) done_cnt++;
        if (wr.wr_valid_out && wr.wr_ready_in) begin
            wa_q.push_back(int'(wr.wr_addr_out));
            we_q.push_back(cyc + 1);
            wd_q.push_back(int'(wr.wr_data_out));
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        $display("check %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        we_q.delete();
        wd_q.delete();
    endtask

    task automatic start_stamp(input int x, input int y, input int c, input int r,
                               output int n);
        cursor_x     = 10'(x);
        cursor_y     = 9'(y);
        color        = 4'(c);
        stroke_width = 3'(r);
        draw_en      = 1'b1;
        nf           = 1'b1;
        n            = cyc + 1;
        tick();
        nf = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int pre;
        bit seen;
        pre  = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (done_cnt > pre) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic chk_addrs(input string tag, input int unsigned exp[]);
        chk({tag, "_count"}, 32'(wa_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wa_q.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), wa_q[i], exp[i]);
    endtask

    initial begin
        int n;
        bit stalled;
        int unsigned exp2[] = '{0, 1, 2, 640, 641, 642, 1280, 1281, 1282};
        int unsigned exp3[] = '{229757, 229758, 229759, 230397, 230398, 230399};
        int unsigned exp4[] = '{5769, 5770, 5771, 6409, 6410, 6411, 7049, 7050, 7051};

        rst_n = 1'b0; cursor_x = '0; cursor_y = '0; color = '0;
        stroke_width = '0; draw_en = 1'b0; nf = 1'b0; wr.wr_ready_in = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(wr.wr_valid_out), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_miss",  32'(frame_miss), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single pixel at centre: handshake at N+2, done high after N+3
        clear_log();
        start_stamp(320, 180, 5, 0, n);
        wait_done("t1");
        chk("t1_count", 32'(wa_q.size()), 1);
        if (wa_q.size() > 0) begin
            chk("t1_addr", wa_q[0], 115520);
            chk("t1_data", wd_q[0], 5);
            chk("t1_edge", 32'(we_q[0]), 32'(n + 2));
        end
        chk("t1_busy_pre",  32'(busy_hist[(n - 1) & 8191]), 0);
        chk("t1_busy_n0",   32'(busy_hist[n & 8191]), 1);
        chk("t1_busy_n1",   32'(busy_hist[(n + 1) & 8191]), 1);
        chk("t1_busy_n2",   32'(busy_hist[(n + 2) & 8191]), 1);
        chk("t1_busy_n3",   32'(busy_hist[(n + 3) & 8191]), 0);
        chk("t1_done_n2",   32'(done_hist[(n + 2) & 8191]), 0);
        chk("t1_done_n3",   32'(done_hist[(n + 3) & 8191]), 1);

        // Top-left corner clip, back-to-back writes
        clear_log();
        start_stamp(0, 0, 9, 2, n);
        wait_done("t2");
        chk_addrs("t2", exp2);
        for (int i = 0; i < we_q.size(); i++)
            chk($sformatf("t2_edge%0d", i), 32'(we_q[i]), 32'(n + 2 + i));

        // Bottom-right corner clip
        clear_log();
        start_stamp(638, 359, 2, 1, n);
        wait_done("t3");
        chk_addrs("t3", exp3);

        // Stall on pixel (11,10); inputs changed after capture
        clear_log();
        start_stamp(10, 10, 3, 1, n);
        cursor_x = 10'd100; cursor_y = 9'd100; color = 4'd12;
        stroke_width = 3'd7; draw_en = 1'b0;
        stalled = 1'b0;
        for (int i = 0; i < 50 && !stalled; i++) begin
            if (wr.wr_valid_out && wr.wr_addr_out == 18'd6411) begin
                wr.wr_ready_in = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk($sformatf("t4_hold_valid%0d", k), 32'(wr.wr_valid_out), 1);
                    chk($sformatf("t4_hold_addr%0d", k), 32'(wr.wr_addr_out), 6411);
                    chk($sformatf("t4_hold_data%0d", k), 32'(wr.wr_data_out), 3);
                end
                wr.wr_ready_in = 1'b1;
                stalled = 1'b1;
            end else begin
                tick();
            end
        end
        chk("t4_stall_reached", 32'(stalled), 1);
        wait_done("t4");
        chk_addrs("t4", exp4);
        for (int i = 0; i < wd_q.size(); i++)
            chk($sformatf("t4_data%0d", i), wd_q[i], 3);

        // New-frame strobe mid-stamp: miss flagged, stamp unchanged
        clear_log();
        chk("t5_miss_before", 32'(frame_miss), 0);
        start_stamp(100, 50, 7, 1, n);
        repeat (2) tick();
        nf = 1'b1;
        tick();
        nf = 1'b0;
        wait_done("t5");
        chk("t5_count", 32'(wa_q.size()), 9);
        if (wa_q.size() == 9) begin
            chk("t5_first", wa_q[0], 31459);
            chk("t5_last",  wa_q[8], 32741);
        end
        repeat (5) tick();
        chk("t5_miss_sticky", 32'(frame_miss), 1);

        // nf with drawing disabled in IDLE
        clear_log();
        draw_en = 1'b0;
        nf = 1'b1;
        tick();
        nf = 1'b0;
        repeat (10) tick();
        chk("t6_no_writes", 32'(wa_q.size()), 0);
        chk("t6_idle_busy", 32'(busy), 0);

        // Cursor beyond right edge: empty clip, done with zero writes
        clear_log();
        start_stamp(700, 20, 4, 2, n);
        wait_done("t7");
        chk("t7_no_writes", 32'(wa_q.size()), 0);

        // Asynchronous reset mid-stamp between edges
        clear_log();
        start_stamp(200, 100, 6, 7, n);
        repeat (10) tick();
        chk("t8_valid_pre", 32'(wr.wr_valid_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_rst_valid", 32'(wr.wr_valid_out), 0);
        chk("t8_rst_busy",  32'(busy), 0);
        chk("t8_rst_miss",  32'(frame_miss), 0);
        tick();
        rst_n = 1'b1;
        clear_log();
        repeat (20) tick();
        chk("t8_post_idle_writes", 32'(wa_q.size()), 0);
        chk("t8_post_idle_busy",   32'(busy), 0);
        start_stamp(5, 5, 1, 0, n);
        wait_done("t8");
        chk("t8_count", 32'(wa_q.size()), 1);
        if (wa_q.size() > 0) chk("t8_addr", wa_q[0], 3205);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
